// File: rtl/axi_lite_regfile_slave.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile_slave
//
// AXI4-Lite slave front end for the control register file. Each bus write
// becomes a single-cycle write strobe towards the register file, and each bus
// read samples the register file's combinational read port. One write and one
// read may be outstanding at a time; the two paths run independently.
// Out-of-range addresses (any bit above [5:2] set) and partial byte strobes
// are answered with SLVERR and never reach the register file.
//
// Ports
//   clk, resetn          system clock (rising edge), async active-low reset
//   s_axi_aw*            write-address channel (awaddr, awvalid, awready)
//   s_axi_w*             write-data channel (wdata, wstrb, wvalid, wready)
//   s_axi_b*             write-response channel (bresp, bvalid, bready)
//   s_axi_ar*            read-address channel (araddr, arvalid, arready)
//   s_axi_r*             read-data channel (rdata, rresp, rvalid, rready)
//   write_addr/data/en   register file write port, write_en is a 1-cycle pulse
//   read_addr/read_data  register file combinational read port
// -----------------------------------------------------------------------------
module axi_lite_regfile_slave #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,

    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,

    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,

    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,

    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,

    output logic [3:0]            write_addr,
    output logic [31:0]           write_data,
    output logic                  write_en,

    output logic [3:0]            read_addr,
    input  logic [31:0]           read_data
);

    localparam logic [1:0] W_COLLECT = 2'd0;
    localparam logic [1:0] W_COMMIT  = 2'd1;
    localparam logic [1:0] W_RESP    = 2'd2;

    localparam logic [1:0] R_IDLE    = 2'd0;
    localparam logic [1:0] R_FETCH   = 2'd1;
    localparam logic [1:0] R_RESP    = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write path state
    logic [1:0] wstate;
    logic       aw_held;
    logic       w_held;
    logic       aw_ok_q;     // latched address range check
    logic       strb_ok_q;   // latched full-word strobe check
    logic       wr_legal;    // verdict of the write being committed

    // Read path state
    logic [1:0] rstate;
    logic       rd_ok;

    // Combinational helpers
    logic aw_hs;
    logic w_hs;
    logic aw_ok_in;
    logic strb_ok_in;
    logic aw_held_nx;
    logic w_held_nx;
    logic commit_nx;
    logic legal_nx;
    logic ar_hs;
    logic ar_ok_in;

    // Byte-lane bits of the addresses carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_comb begin
        aw_hs      = s_axi_awvalid && s_axi_awready;
        w_hs       = s_axi_wvalid && s_axi_wready;
        aw_ok_in   = (s_axi_awaddr[ADDR_WIDTH-1:6] == '0);
        strb_ok_in = (s_axi_wstrb == 4'b1111);
        aw_held_nx = aw_held || aw_hs;
        w_held_nx  = w_held || w_hs;
        commit_nx  = (wstate == W_COLLECT) && aw_held_nx && w_held_nx;
        // The second half of the pair may be arriving this very cycle, so the
        // legality check takes the live input for whichever side handshakes now.
        legal_nx   = (aw_hs ? aw_ok_in : aw_ok_q) && (w_hs ? strb_ok_in : strb_ok_q);
        ar_hs      = s_axi_arvalid && s_axi_arready;
        ar_ok_in   = (s_axi_araddr[ADDR_WIDTH-1:6] == '0);
    end

    // -------------------------------------------------------------------------
    // Write path: collect AW and W in any order, commit for one cycle, respond.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate        <= W_COLLECT;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_ok_q       <= 1'b0;
            strb_ok_q     <= 1'b0;
            wr_legal      <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            write_addr    <= '0;
            write_data    <= '0;
            write_en      <= 1'b0;
        end else begin
            case (wstate)
                W_COLLECT: begin
                    aw_held <= aw_held_nx;
                    w_held  <= w_held_nx;
                    if (aw_hs) begin
                        write_addr <= s_axi_awaddr[5:2];
                        aw_ok_q    <= aw_ok_in;
                    end
                    if (w_hs) begin
                        write_data <= s_axi_wdata;
                        strb_ok_q  <= strb_ok_in;
                    end
                    if (commit_nx) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        write_en      <= legal_nx;
                        wr_legal      <= legal_nx;
                        wstate        <= W_COMMIT;
                    end else begin
                        s_axi_awready <= !aw_held_nx;
                        s_axi_wready  <= !w_held_nx;
                    end
                end
                W_COMMIT: begin
                    write_en     <= 1'b0;
                    s_axi_bvalid <= 1'b1;
                    s_axi_bresp  <= wr_legal ? RESP_OKAY : RESP_SLVERR;
                    wstate       <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        wstate        <= W_COLLECT;
                    end
                end
                default: begin
                    write_en <= 1'b0;
                    wstate   <= W_COLLECT;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Read path: accept AR, sample the register file one cycle later, respond.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate        <= R_IDLE;
            rd_ok         <= 1'b0;
            read_addr     <= '0;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (ar_hs) begin
                        read_addr     <= s_axi_araddr[5:2];
                        rd_ok         <= ar_ok_in;
                        s_axi_arready <= 1'b0;
                        rstate        <= R_FETCH;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_FETCH: begin
                    // Sampled in the same cycle a concurrent write_en may be
                    // high, so the pre-write contents are returned.
                    s_axi_rdata  <= rd_ok ? read_data : '0;
                    s_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                    s_axi_rvalid <= 1'b1;
                    rstate       <= R_RESP;
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        rstate        <= R_IDLE;
                    end
                end
                default: begin
                    rstate <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_regfile_slave
//
// Self-checking bench for axi_lite_regfile_slave. A simple 16 x 32 register
// file is attached to the DUT's register-file ports; ref_mem holds the
// contents expected from the bus-level rules (legal writes land, illegal ones
// do not), and reads are compared against it.
// -----------------------------------------------------------------------------
module tb_axi_lite_regfile_slave;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [3:0]  write_addr;
    logic [31:0] write_data;
    logic        write_en;
    logic [3:0]  read_addr;
    logic [31:0] read_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [16];
    logic [31:0] env_mem [16];
    logic        clear_mem;

    int          we_seen = 0;
    logic [3:0]  we_addr_last = '0;
    logic [31:0] we_data_last = '0;
    logic        we_prev = 1'b0;

    always #5 clk = ~clk;

    axi_lite_regfile_slave #(.ADDR_WIDTH(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .write_en      (write_en),
        .read_addr     (read_addr),
        .read_data     (read_data)
    );

    // Attached register file: write on the clock edge, combinational read.
    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 16; i++) env_mem[i] <= '0;
        end else if (write_en) begin
            env_mem[write_addr] <= write_data;
        end
    end
    assign read_data = env_mem[read_addr];

    // Write strobe monitor: records each pulse and flags back-to-back pulses.
    always @(negedge clk) begin
        if (resetn && write_en) begin
            we_seen++;
            we_addr_last = write_addr;
            we_data_last = write_data;
            total++;
            if (we_prev) begin
                bad++;
                $display("FAIL write_en_single: high two cycles in a row, got 1 required 0");
            end
        end
        we_prev = resetn && write_en;
    end

    function automatic logic [81:0] all_outs();
        return {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
                s_axi_rvalid, s_axi_rresp, s_axi_rdata, write_en, write_addr, write_data, read_addr};
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, output logic [1:0] resp, output bit ok);
        int   cyc;
        bit   aw_done;
        bit   w_done;
        bit   b_done;
        logic aw_rdy;
        logic w_rdy;
        ok = 1'b1; resp = 2'b11; aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0; cyc = 0;
        s_axi_bready = 1'b1;
        while (!(aw_done && w_done) && cyc < 100) begin
            if (!aw_done && cyc >= aw_dly) begin s_axi_awaddr = addr; s_axi_awvalid = 1'b1; end
            if (!w_done && cyc >= w_dly) begin
                s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
            end
            aw_rdy = s_axi_awready;
            w_rdy  = s_axi_wready;
            @(negedge clk); cyc++;
            if (s_axi_awvalid && aw_rdy) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
            if (s_axi_wvalid && w_rdy) begin w_done = 1'b1; s_axi_wvalid = 1'b0; end
        end
        if (!(aw_done && w_done)) begin ok = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; end
        cyc = 0;
        while (ok && !b_done && cyc < 100) begin
            if (s_axi_bvalid) begin resp = s_axi_bresp; b_done = 1'b1; end
            @(negedge clk); cyc++;
        end
        if (!b_done) ok = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input int ar_dly,
                            output logic [31:0] data, output logic [1:0] resp, output bit ok);
        int   cyc;
        bit   done;
        logic rdy;
        ok = 1'b1; data = '0; resp = 2'b11; done = 1'b0; cyc = 0;
        s_axi_rready = 1'b1;
        while (!done && cyc < 100) begin
            if (cyc >= ar_dly) begin s_axi_araddr = addr; s_axi_arvalid = 1'b1; end
            rdy = s_axi_arready;
            @(negedge clk); cyc++;
            if (s_axi_arvalid && rdy) begin done = 1'b1; s_axi_arvalid = 1'b0; end
        end
        if (!done) begin ok = 1'b0; s_axi_arvalid = 1'b0; end
        done = 1'b0; cyc = 0;
        while (ok && !done && cyc < 100) begin
            if (s_axi_rvalid) begin data = s_axi_rdata; resp = s_axi_rresp; done = 1'b1; end
            @(negedge clk); cyc++;
        end
        if (!done) ok = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; clear_mem = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (all_outs() !== '0) begin
            bad++; $display("FAIL reset_outputs: got %h required 0", all_outs());
        end
        resetn = 1'b1; clear_mem = 1'b0;
        #1;
        total++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
            bad++; $display("FAIL ready_before_edge: got %b required 000",
                            {s_axi_awready, s_axi_wready, s_axi_arready});
        end
        @(negedge clk);
        total++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, write_en} !== 6'b111000) begin
            bad++; $display("FAIL ready_after_reset: got %b required 111000",
                            {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, write_en});
        end
    endtask

    task automatic test_write_same_cycle();
        logic [31:0] rd;
        logic [1:0]  rr;
        bit          ok;
        s_axi_bready = 1'b1;
        s_axi_awaddr = 32'h04; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h0000_0780; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(negedge clk);
        total++;
        if ({write_en, write_addr, write_data} !== {1'b1, 4'd1, 32'h0000_0780}) begin
            bad++; $display("FAIL same_cycle_strobe: got en=%b addr=%0d data=%h required en=1 addr=1 data=00000780",
                            write_en, write_addr, write_data);
        end
        total++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b000) begin
            bad++; $display("FAIL same_cycle_commit_ready: got %b required 000",
                            {s_axi_awready, s_axi_wready, s_axi_bvalid});
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(negedge clk);
        total++;
        if ({write_en, s_axi_bvalid, s_axi_bresp} !== 4'b0100) begin
            bad++; $display("FAIL same_cycle_bresp: got %b required 0100", {write_en, s_axi_bvalid, s_axi_bresp});
        end
        @(negedge clk);
        total++;
        if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b011) begin
            bad++; $display("FAIL same_cycle_after_b: got %b required 011",
                            {s_axi_bvalid, s_axi_awready, s_axi_wready});
        end
        ref_mem[1] = 32'h0000_0780;
        bus_read(32'h04, 0, rd, rr, ok);
        total++;
        if (!ok || rd !== ref_mem[1] || rr !== 2'b00) begin
            bad++; $display("FAIL same_cycle_readback: got ok=%0d data=%h resp=%b required ok=1 data=%h resp=00",
                            ok, rd, rr, ref_mem[1]);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] rd;
        logic [1:0]  rr;
        bit          ok;
        s_axi_wdata = 32'h1E; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            s_axi_wvalid = 1'b0;
            total++;
            if ({s_axi_wready, s_axi_awready, write_en} !== 3'b010) begin
                bad++; $display("FAIL w_first_wait_c%0d: got wready,awready,en=%b required 010",
                                c, {s_axi_wready, s_axi_awready, write_en});
            end
        end
        s_axi_awaddr = 32'h08; s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        total++;
        if ({write_en, write_addr, write_data, s_axi_awready} !== {1'b1, 4'd2, 32'h1E, 1'b0}) begin
            bad++; $display("FAIL w_first_strobe: got en=%b addr=%0d data=%h awready=%b required 1 2 0000001e 0",
                            write_en, write_addr, write_data, s_axi_awready);
        end
        @(negedge clk);
        total++;
        if ({write_en, s_axi_bvalid, s_axi_bresp} !== 4'b0100) begin
            bad++; $display("FAIL w_first_bresp: got %b required 0100", {write_en, s_axi_bvalid, s_axi_bresp});
        end
        @(negedge clk);
        ref_mem[2] = 32'h1E;
        bus_read(32'h08, 0, rd, rr, ok);
        total++;
        if (!ok || rd !== ref_mem[2] || rr !== 2'b00) begin
            bad++; $display("FAIL w_first_readback: got ok=%0d data=%h resp=%b required ok=1 data=%h resp=00",
                            ok, rd, rr, ref_mem[2]);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] rd;
        logic [1:0]  rr;
        bit          ok;
        int          we0;
        we0 = we_seen;
        bus_write(32'h40, $urandom, 4'hF, 0, 0, rr, ok);
        total++;
        if (!ok || rr !== 2'b10 || we_seen != we0) begin
            bad++; $display("FAIL illegal_range_write: got ok=%0d resp=%b strobes=%0d required ok=1 resp=10 strobes=0",
                            ok, rr, we_seen - we0);
        end
        we0 = we_seen;
        bus_write(32'h0C, $urandom, 4'b0011, 1, 0, rr, ok);
        total++;
        if (!ok || rr !== 2'b10 || we_seen != we0) begin
            bad++; $display("FAIL illegal_strobe_write: got ok=%0d resp=%b strobes=%0d required ok=1 resp=10 strobes=0",
                            ok, rr, we_seen - we0);
        end
        bus_read(32'h40, 0, rd, rr, ok);
        total++;
        if (!ok || rd !== 32'h0 || rr !== 2'b10) begin
            bad++; $display("FAIL illegal_read: got ok=%0d data=%h resp=%b required ok=1 data=00000000 resp=10",
                            ok, rd, rr);
        end
    endtask

    task automatic test_bready_stall();
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] rd;
        logic [1:0]  rr;
        bit          ok;
        d1 = $urandom; d2 = $urandom;
        s_axi_bready = 1'b0;
        s_axi_awaddr = 32'h14; s_axi_awvalid = 1'b1;
        s_axi_wdata = d1; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(negedge clk);
        total++;
        if ({write_en, write_addr} !== {1'b1, 4'd5}) begin
            bad++; $display("FAIL stall_first_strobe: got en=%b addr=%0d required en=1 addr=5", write_en, write_addr);
        end
        // Second write presented straight away; it must wait for the B handshake.
        s_axi_awaddr = 32'h18; s_axi_wdata = d2;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready, write_en} !== 6'b100000) begin
                bad++; $display("FAIL stall_hold_c%0d: got bvalid,bresp,awready,wready,en=%b required 100000",
                                c, {s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready, write_en});
            end
        end
        s_axi_bready = 1'b1;
        @(negedge clk);
        total++;
        if ({s_axi_bvalid, s_axi_awready, s_axi_wready, write_en} !== 4'b0110) begin
            bad++; $display("FAIL stall_release: got %b required 0110",
                            {s_axi_bvalid, s_axi_awready, s_axi_wready, write_en});
        end
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        total++;
        if ({write_en, write_addr, write_data} !== {1'b1, 4'd6, d2}) begin
            bad++; $display("FAIL stall_second_strobe: got en=%b addr=%0d data=%h required en=1 addr=6 data=%h",
                            write_en, write_addr, write_data, d2);
        end
        repeat (2) @(negedge clk);
        ref_mem[5] = d1;
        ref_mem[6] = d2;
        for (int i = 5; i <= 6; i++) begin
            bus_read(32'(i * 4), 0, rd, rr, ok);
            total++;
            if (!ok || rd !== ref_mem[i] || rr !== 2'b00) begin
                bad++; $display("FAIL stall_readback_%0d: got ok=%0d data=%h resp=%b required ok=1 data=%h resp=00",
                                i, ok, rd, rr, ref_mem[i]);
            end
        end
    endtask

    task automatic test_read_during_write();
        logic [31:0] old;
        logic [31:0] rd;
        logic [1:0]  rr;
        bit          ok;
        old = ref_mem[3];
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        s_axi_awaddr = 32'h0C; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hAA; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        s_axi_araddr = 32'h0C; s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        total++;
        if ({write_en, write_addr, s_axi_arready, s_axi_rvalid, read_addr} !== {1'b1, 4'd3, 1'b0, 1'b0, 4'd3}) begin
            bad++; $display("FAIL rdw_fetch_cycle: got en=%b waddr=%0d arready=%b rvalid=%b raddr=%0d required 1 3 0 0 3",
                            write_en, write_addr, s_axi_arready, s_axi_rvalid, read_addr);
        end
        @(negedge clk);
        total++;
        if ({s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_bvalid} !== {1'b1, old, 2'b00, 1'b1}) begin
            bad++; $display("FAIL rdw_old_value: got rvalid=%b rdata=%h rresp=%b bvalid=%b required 1 %h 00 1",
                            s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_bvalid, old);
        end
        @(negedge clk);
        total++;
        if ({s_axi_rvalid, s_axi_bvalid, s_axi_arready} !== 3'b001) begin
            bad++; $display("FAIL rdw_complete: got %b required 001", {s_axi_rvalid, s_axi_bvalid, s_axi_arready});
        end
        ref_mem[3] = 32'hAA;
        bus_read(32'h0C, 0, rd, rr, ok);
        total++;
        if (!ok || rd !== ref_mem[3] || rr !== 2'b00) begin
            bad++; $display("FAIL rdw_new_value: got ok=%0d data=%h resp=%b required ok=1 data=%h resp=00",
                            ok, rd, rr, ref_mem[3]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [1:0]  rr;
        bit          ok;
        s_axi_awaddr = 32'h1C; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        total++;
        if (write_en !== 1'b1) begin
            bad++; $display("FAIL mid_reset_commit: got en=%b required 1", write_en);
        end
        #2 resetn = 1'b0;
        #1;
        total++;
        if (all_outs() !== '0) begin
            bad++; $display("FAIL mid_reset_async: got %h required 0", all_outs());
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, write_en} !== 5'b11100) begin
                bad++; $display("FAIL mid_reset_after_c%0d: got %b required 11100",
                                c, {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, write_en});
            end
        end
        bus_read(32'h1C, 0, rd, rr, ok);
        total++;
        if (!ok || rd !== ref_mem[7] || rr !== 2'b00) begin
            bad++; $display("FAIL mid_reset_no_write: got ok=%0d data=%h resp=%b required ok=1 data=%h resp=00",
                            ok, rd, rr, ref_mem[7]);
        end
    endtask

    task automatic test_random();
        logic [31:0] waddr;
        logic [31:0] wdat;
        logic [3:0]  wstrb;
        logic [31:0] raddr;
        logic [31:0] rd;
        logic [31:0] rexp;
        logic [1:0]  wr;
        logic [1:0]  rr;
        bit          wok;
        bit          rok;
        bit          legal;
        bit          rlegal;
        int          we0;
        int          mode;
        int          b;
        for (int it = 0; it < 40; it++) begin
            mode  = int'($urandom_range(0, 2));
            waddr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) begin b = 6 + int'($urandom_range(0, 25)); waddr[b] = 1'b1; end
            wstrb = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            wdat  = $urandom;
            legal = (waddr[31:6] == 26'd0) && (wstrb == 4'hF);
            raddr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if (mode == 2 && raddr[5:2] == waddr[5:2]) raddr[5:2] = waddr[5:2] + 4'd1;
            if ($urandom_range(0, 7) == 0) begin b = 6 + int'($urandom_range(0, 25)); raddr[b] = 1'b1; end
            rlegal = (raddr[31:6] == 26'd0);
            rexp   = rlegal ? ref_mem[raddr[5:2]] : 32'h0;
            we0 = we_seen;
            if (mode == 0) begin
                bus_write(waddr, wdat, wstrb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), wr, wok);
            end else if (mode == 1) begin
                bus_read(raddr, int'($urandom_range(0, 2)), rd, rr, rok);
            end else begin
                fork
                    bus_write(waddr, wdat, wstrb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), wr, wok);
                    bus_read(raddr, int'($urandom_range(0, 2)), rd, rr, rok);
                join
            end
            if (mode != 1) begin
                total++;
                if (!wok || wr !== (legal ? 2'b00 : 2'b10) || (we_seen - we0) != (legal ? 1 : 0) ||
                    (legal && (we_addr_last !== waddr[5:2] || we_data_last !== wdat))) begin
                    bad++; $display("FAIL rand_write_%0d: got ok=%0d resp=%b strobes=%0d addr=%0d data=%h required resp=%b strobes=%0d addr=%0d data=%h",
                                    it, wok, wr, we_seen - we0, we_addr_last, we_data_last,
                                    legal ? 2'b00 : 2'b10, legal ? 1 : 0, waddr[5:2], wdat);
                end
                if (legal) ref_mem[waddr[5:2]] = wdat;
            end
            if (mode != 0) begin
                total++;
                if (!rok || rd !== rexp || rr !== (rlegal ? 2'b00 : 2'b10)) begin
                    bad++; $display("FAIL rand_read_%0d: got ok=%0d data=%h resp=%b required ok=1 data=%h resp=%b",
                                    it, rok, rd, rr, rexp, rlegal ? 2'b00 : 2'b10);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; clear_mem = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_illegal();
        test_bready_stall();
        test_read_during_write();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
